// File: rtl/logic_expr_pkg.sv
// Shared definitions for the logic expression pipeline.
//   sel_t      : result select code driving the y multiplexer
//   WIDTH_DEF  : default operand/result width
//   CNT_W_DEF  : default width of the output transaction counter
package logic_expr_pkg;

  typedef enum logic [1:0] {
    SEL_S1  = 2'b00,
    SEL_S2  = 2'b01,
    SEL_S3  = 2'b10,
    SEL_XOR = 2'b11
  } sel_t;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 16;

endpackage : logic_expr_pkg

// File: rtl/logic_expr_core.sv
// Purely combinational bitwise expression core.
// Ports:
//   a, b, c, d : operand vectors (WIDTH bits)
//   sel        : chooses which result drives y
//   s1, s2, s3 : bitwise expression results
//   y          : selected result (s1, s2, s3 or their XOR)
module logic_expr_core
  import logic_expr_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  sel_t             sel,
  output logic [WIDTH-1:0] s1,
  output logic [WIDTH-1:0] s2,
  output logic [WIDTH-1:0] s3,
  output logic [WIDTH-1:0] y
);

  assign s1 = a & ~b;
  assign s2 = (a & b) | (c & d);
  assign s3 = (a & ~b) | ~(c & (a | d));

  always_comb begin
    y = s1;
    case (sel)
      SEL_S1:  y = s1;
      SEL_S2:  y = s2;
      SEL_S3:  y = s3;
      SEL_XOR: y = s1 ^ s2 ^ s3;
      default: y = s1;
    endcase
  end

endmodule : logic_expr_core

// File: rtl/logic_expr_pipe.sv
// Two-stage valid/ready pipeline around logic_expr_core.
// Stage 1 captures s1..s3 and y; stage 2 holds that data plus the popcount
// of y. Each stage advances when it is empty or the stage after it drains.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid / in_ready   : input handshake (in_ready is 0 during reset)
//   a, b, c, d, sel       : operands and result select
//   out_valid / out_ready : output handshake
//   s1, s2, s3, y, pop    : registered results, pop = ones count of y
//   txn_count             : number of completed output handshakes (wraps)
module logic_expr_pipe
  import logic_expr_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  localparam int PW   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  sel_t             sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s1,
  output logic [WIDTH-1:0] s2,
  output logic [WIDTH-1:0] s3,
  output logic [WIDTH-1:0] y,
  output logic [PW-1:0]    pop,
  output logic [CNT_W-1:0] txn_count
);

  logic [WIDTH-1:0] s1_d, s2_d, s3_d, y_d;
  logic [WIDTH-1:0] s1_1_q, s2_1_q, s3_1_q, y_1_q;
  logic [WIDTH-1:0] s1_2_q, s2_2_q, s3_2_q, y_2_q;
  logic [PW-1:0]    pop_d, pop_q;
  logic [CNT_W-1:0] txn_d, txn_q;
  logic             v1_q, v2_q;
  logic             adv1, adv2;

  logic_expr_core #(.WIDTH(WIDTH)) u_core (
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .sel (sel),
    .s1  (s1_d),
    .s2  (s2_d),
    .s3  (s3_d),
    .y   (y_d)
  );

  assign adv2     = !v2_q || out_ready;
  assign adv1     = !v1_q || adv2;
  // Gate with rst_n so nothing appears accepted while reset is held.
  assign in_ready = rst_n && adv1;

  always_comb begin
    pop_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop_d = pop_d + PW'(y_1_q[i]);
    end
  end

  assign txn_d = txn_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      s1_1_q <= '0;
      s2_1_q <= '0;
      s3_1_q <= '0;
      y_1_q  <= '0;
      s1_2_q <= '0;
      s2_2_q <= '0;
      s3_2_q <= '0;
      y_2_q  <= '0;
      pop_q  <= '0;
      txn_q  <= '0;
    end else begin
      if (adv1) begin
        v1_q <= in_valid;
        // Data only loads on a real transfer; otherwise it simply holds.
        if (in_valid) begin
          s1_1_q <= s1_d;
          s2_1_q <= s2_d;
          s3_1_q <= s3_d;
          y_1_q  <= y_d;
        end
      end
      if (adv2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          s1_2_q <= s1_1_q;
          s2_2_q <= s2_1_q;
          s3_2_q <= s3_1_q;
          y_2_q  <= y_1_q;
          pop_q  <= pop_d;
        end
      end
      if (v2_q && out_ready) begin
        txn_q <= txn_d;
      end
    end
  end

  assign out_valid = v2_q;
  assign s1        = s1_2_q;
  assign s2        = s2_2_q;
  assign s3        = s3_2_q;
  assign y         = y_2_q;
  assign pop       = pop_q;
  assign txn_count = txn_q;

endmodule : logic_expr_pipe

// File: tb/tb_logic_expr_pipe.sv
// Directed and streaming checks for logic_expr_pipe.
// dut8  : WIDTH=8, CNT_W=4 (directed tests, counter wrap)
// dut64 / dut1 : WIDTH=64 and WIDTH=1 driven in lockstep by random streaming
module tb_logic_expr_pipe;
  import logic_expr_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // 8-bit instance
  logic       in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0] a8, b8, c8, d8, s1_8, s2_8, s3_8, y8;
  sel_t       sel8;
  logic [3:0] pop8;
  logic [3:0] txn8;

  // shared stimulus for the 64-bit and 1-bit instances
  logic        in_valid_r, out_ready_r;
  logic [63:0] a64, b64, c64, d64;
  sel_t        sel_r;
  logic        in_ready64, out_valid64, in_ready1, out_valid1;
  logic [63:0] s1_64, s2_64, s3_64, y64;
  logic [6:0]  pop64;
  logic [15:0] txn64, txn1;
  logic        s1_1, s2_1, s3_1, y1, pop1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] s1, s2, s3, y;
  } res_t;

  logic_expr_pipe #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .c(c8), .d(d8), .sel(sel8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .s1(s1_8), .s2(s2_8), .s3(s3_8), .y(y8), .pop(pop8), .txn_count(txn8)
  );

  logic_expr_pipe #(.WIDTH(64), .CNT_W(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_r), .in_ready(in_ready64),
    .a(a64), .b(b64), .c(c64), .d(d64), .sel(sel_r),
    .out_valid(out_valid64), .out_ready(out_ready_r),
    .s1(s1_64), .s2(s2_64), .s3(s3_64), .y(y64), .pop(pop64), .txn_count(txn64)
  );

  logic_expr_pipe #(.WIDTH(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_r), .in_ready(in_ready1),
    .a(a64[0]), .b(b64[0]), .c(c64[0]), .d(d64[0]), .sel(sel_r),
    .out_valid(out_valid1), .out_ready(out_ready_r),
    .s1(s1_1), .s2(s2_1), .s3(s3_1), .y(y1), .pop(pop1), .txn_count(txn1)
  );

  function automatic res_t ref_model(input logic [63:0] a, input logic [63:0] b,
                                     input logic [63:0] c, input logic [63:0] d,
                                     input logic [1:0] sel);
    res_t r;
    r.s1 = a & ~b;
    r.s2 = (a & b) | (c & d);
    r.s3 = (a & ~b) | ~(c & (a | d));
    case (sel)
      2'b00:   r.y = r.s1;
      2'b01:   r.y = r.s2;
      2'b10:   r.y = r.s3;
      default: r.y = r.s1 ^ r.s2 ^ r.s3;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid8 = 1'b1; out_ready8 = 1'b1;
    a8 = 8'hFF; b8 = 8'h00; c8 = 8'hFF; d8 = 8'hFF; sel8 = SEL_S3;
    tick();
    tick();
    checks++;
    if (in_ready8 !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready8); end
    checks++;
    if (out_valid8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid8); end
    checks++;
    if ({s1_8, s2_8, s3_8, y8, pop8, txn8} !== 40'h0) begin
      errors++; $display("FAIL reset_data: s1=%h s2=%h s3=%h y=%h pop=%0d txn=%0d expected all 0",
                        s1_8, s2_8, s3_8, y8, pop8, txn8);
    end
    $display("test_reset: in_ready=%b out_valid=%b y=%h", in_ready8, out_valid8, y8);
  endtask

  task automatic test_basic();
    rst_n = 1'b1;
    in_valid8 = 1'b1; out_ready8 = 1'b1;
    a8 = 8'hF0; b8 = 8'hCC; c8 = 8'hAA; d8 = 8'h0F; sel8 = SEL_S2;
    #1;
    checks++;
    if (in_ready8 !== 1'b1) begin errors++; $display("FAIL first_accept: in_ready=%b expected 1", in_ready8); end
    tick();
    in_valid8 = 1'b0;
    checks++;
    if (out_valid8 !== 1'b0) begin errors++; $display("FAIL latency_early: out_valid=%b expected 0", out_valid8); end
    tick();
    checks++;
    if (out_valid8 !== 1'b1 || s1_8 !== 8'h30 || s2_8 !== 8'hCA || s3_8 !== 8'h75 ||
        y8 !== 8'hCA || pop8 !== 4'd4) begin
      errors++;
      $display("FAIL basic_result: v=%b s1=%h s2=%h s3=%h y=%h pop=%0d expected v=1 s1=30 s2=CA s3=75 y=CA pop=4",
               out_valid8, s1_8, s2_8, s3_8, y8, pop8);
    end
    tick();
    checks++;
    if (txn8 !== 4'd1 || out_valid8 !== 1'b0) begin
      errors++; $display("FAIL basic_txn: txn=%0d v=%b expected txn=1 v=0", txn8, out_valid8);
    end
    $display("test_basic: y=CA txn=%0d", txn8);
  endtask

  task automatic test_xor();
    in_valid8 = 1'b1; sel8 = SEL_XOR;
    #1;
    tick();
    in_valid8 = 1'b0;
    tick();
    checks++;
    if (out_valid8 !== 1'b1 || y8 !== 8'h8F || pop8 !== 4'd5) begin
      errors++; $display("FAIL xor_result: v=%b y=%h pop=%0d expected v=1 y=8F pop=5", out_valid8, y8, pop8);
    end
    tick();
    checks++;
    if (txn8 !== 4'd2) begin errors++; $display("FAIL xor_txn: txn=%0d expected 2", txn8); end
    $display("test_xor: txn=%0d", txn8);
  endtask

  task automatic test_backpressure();
    logic [7:0] va[4], vb[4], vc[4], vd[4];
    res_t exp8[4];
    int idx = 0;
    int rcv = 0;
    logic acc;
    va = '{8'hF0, 8'h5A, 8'h33, 8'hFF};
    vb = '{8'hCC, 8'h0F, 8'h99, 8'h01};
    vc = '{8'hAA, 8'hC3, 8'h66, 8'h80};
    vd = '{8'h0F, 8'h3C, 8'hE1, 8'h7E};
    for (int i = 0; i < 4; i++) exp8[i] = ref_model({56'h0, va[i]}, {56'h0, vb[i]},
                                                    {56'h0, vc[i]}, {56'h0, vd[i]}, 2'(i));
    out_ready8 = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      in_valid8 = 1'b1;
      a8 = va[idx]; b8 = vb[idx]; c8 = vc[idx]; d8 = vd[idx]; sel8 = sel_t'(idx);
      #1;
      if (cyc >= 2) begin
        checks++;
        if (in_ready8 !== 1'b0) begin errors++; $display("FAIL bp_in_ready: cycle %0d in_ready=%b expected 0", cyc, in_ready8); end
        checks++;
        if (out_valid8 !== 1'b1 || y8 !== exp8[0].y[7:0] || s3_8 !== exp8[0].s3[7:0]) begin
          errors++; $display("FAIL bp_frozen: cycle %0d v=%b y=%h s3=%h expected v=1 y=%h s3=%h",
                            cyc, out_valid8, y8, s3_8, exp8[0].y[7:0], exp8[0].s3[7:0]);
        end
      end
      acc = in_ready8;
      tick();
      if (acc) idx++;
    end
    checks++;
    if (idx != 2) begin errors++; $display("FAIL bp_accepts: accepted %0d expected 2", idx); end
    out_ready8 = 1'b1;
    for (int k = 0; k < 20 && rcv < 4; k++) begin
      in_valid8 = (idx < 4);
      if (idx < 4) begin
        a8 = va[idx]; b8 = vb[idx]; c8 = vc[idx]; d8 = vd[idx]; sel8 = sel_t'(idx);
      end
      #1;
      if (k == 0) begin
        checks++;
        if (in_ready8 !== 1'b1) begin errors++; $display("FAIL bp_simul_shift: in_ready=%b expected 1", in_ready8); end
      end
      acc = in_valid8 && in_ready8;
      if (out_valid8) begin
        checks++;
        if (y8 !== exp8[rcv].y[7:0] || pop8 !== 4'($countones(exp8[rcv].y[7:0]))) begin
          errors++; $display("FAIL bp_order: item %0d y=%h pop=%0d expected y=%h pop=%0d",
                            rcv, y8, pop8, exp8[rcv].y[7:0], $countones(exp8[rcv].y[7:0]));
        end
        rcv++;
      end
      tick();
      if (acc) idx++;
    end
    in_valid8 = 1'b0;
    #1;
    checks++;
    if (rcv != 4 || idx != 4 || out_valid8 !== 1'b0) begin
      errors++; $display("FAIL bp_drain: received %0d accepted %0d v=%b expected 4 4 0", rcv, idx, out_valid8);
    end
    $display("test_backpressure: accepted=%0d received=%0d", idx, rcv);
  endtask

  task automatic test_wrap();
    int acc = 0;
    int hs = 0;
    logic a_acc, a_hs;
    rst_n = 1'b0; in_valid8 = 1'b0;
    tick();
    rst_n = 1'b1; out_ready8 = 1'b1; sel8 = SEL_S1;
    for (int k = 0; k < 60 && hs < 17; k++) begin
      in_valid8 = (acc < 17);
      a8 = 8'(k);
      #1;
      a_acc = in_valid8 && in_ready8;
      a_hs = out_valid8 && out_ready8;
      tick();
      if (a_acc) acc++;
      if (a_hs) hs++;
    end
    in_valid8 = 1'b0;
    checks++;
    if (hs != 17 || txn8 !== 4'd1) begin
      errors++; $display("FAIL wrap_count: handshakes=%0d txn=%0d expected 17 and 1", hs, txn8);
    end
    $display("test_wrap: handshakes=%0d txn=%0d", hs, txn8);
  endtask

  task automatic test_reset_midflight();
    int stale = 0;
    out_ready8 = 1'b0; in_valid8 = 1'b1;
    a8 = 8'hF0; b8 = 8'hCC; c8 = 8'hAA; d8 = 8'h0F; sel8 = SEL_S3;
    #1;
    tick();
    tick();
    checks++;
    if (out_valid8 !== 1'b1 || in_ready8 !== 1'b0) begin
      errors++; $display("FAIL mid_full: v=%b in_ready=%b expected 1 0", out_valid8, in_ready8);
    end
    rst_n = 1'b0; in_valid8 = 1'b0;
    tick();
    checks++;
    if (out_valid8 !== 1'b0 || {s1_8, s2_8, s3_8, y8, pop8, txn8} !== 40'h0) begin
      errors++; $display("FAIL mid_reset: v=%b s1=%h s2=%h s3=%h y=%h pop=%0d txn=%0d expected all 0",
                        out_valid8, s1_8, s2_8, s3_8, y8, pop8, txn8);
    end
    rst_n = 1'b1; out_ready8 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (out_valid8) stale++;
      tick();
    end
    checks++;
    if (stale != 0) begin errors++; $display("FAIL mid_stale: %0d stale results expected 0", stale); end
    $display("test_reset_midflight: stale=%0d", stale);
  endtask

  task automatic test_random();
    res_t q[$];
    res_t e;
    int n = 0;
    int k;
    rst_n = 1'b0; in_valid_r = 1'b0; out_ready_r = 1'b0;
    tick();
    rst_n = 1'b1;
    for (k = 0; k < 600; k++) begin
      in_valid_r  = (k < 500) ? 1'($urandom_range(0, 1)) : 1'b0;
      out_ready_r = (k < 500) ? 1'($urandom_range(0, 1)) : 1'b1;
      a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
      c64 = {$urandom, $urandom}; d64 = {$urandom, $urandom};
      sel_r = sel_t'($urandom_range(0, 3));
      #1;
      if (in_ready1 !== in_ready64 || out_valid1 !== out_valid64) begin
        checks++; errors++;
        $display("FAIL rnd_lockstep: cycle %0d ready1=%b ready64=%b v1=%b v64=%b", k, in_ready1, in_ready64, out_valid1, out_valid64);
      end
      if (out_valid64 && out_ready_r) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rnd_extra: unexpected result y=%h", y64);
        end else begin
          e = q.pop_front();
          if (y64 !== e.y || s1_64 !== e.s1 || s2_64 !== e.s2 || s3_64 !== e.s3 ||
              pop64 !== 7'($countones(e.y)) || y1 !== e.y[0] || s1_1 !== e.s1[0] ||
              s2_1 !== e.s2[0] || s3_1 !== e.s3[0] || pop1 !== e.y[0]) begin
            errors++;
            $display("FAIL rnd_data: item %0d y64=%h pop64=%0d y1=%b expected y=%h pop=%0d y1=%b",
                     n, y64, pop64, y1, e.y, $countones(e.y), e.y[0]);
          end
          n++;
        end
      end
      if (in_valid_r && in_ready64) q.push_back(ref_model(a64, b64, c64, d64, sel_r));
      tick();
    end
    in_valid_r = 1'b0;
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL rnd_lost: %0d results never emerged", q.size()); end
    checks++;
    if (txn64 !== 16'(n) || txn1 !== 16'(n)) begin
      errors++; $display("FAIL rnd_txn: txn64=%0d txn1=%0d expected %0d", txn64, txn1, n);
    end
    $display("test_random: %0d results streamed", n);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b0;
    a8 = '0; b8 = '0; c8 = '0; d8 = '0; sel8 = SEL_S1;
    in_valid_r = 1'b0; out_ready_r = 1'b0;
    a64 = '0; b64 = '0; c64 = '0; d64 = '0; sel_r = SEL_S1;
    #2;
    test_reset();
    test_basic();
    test_xor();
    test_backpressure();
    test_wrap();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_logic_expr_pipe

// File: doc/logic_expr_pipe.md
LOGIC_EXPR_PIPE -- requirements
Module: logic_expr_pipe

Interface
REQ-001 Parameter WIDTH, default 8: bit width of every operand and result vector; legal range 1..64.
REQ-002 Parameter CNT_W, default 16: width of the transaction counter.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  upstream holds a valid operand set.
REQ-006 in_ready  output  1  block accepts the operand set this cycle.
REQ-007 a, b, c, d  input  WIDTH each  operand vectors.
REQ-008 sel  input  2  result select, of type sel_t (see Structure).
REQ-009 out_valid  output  1  result set valid.
REQ-010 out_ready  input  1  downstream accepts the result set this cycle.
REQ-011 s1, s2, s3  output  WIDTH each  registered bitwise results.
REQ-012 y  output  WIDTH  selected result.
REQ-013 pop  output  $clog2(WIDTH+1)  number of 1 bits in y.
REQ-014 txn_count  output  CNT_W  count of completed output handshakes.

Function
REQ-015 Bitwise results SHALL be: s1 = a & ~b; s2 = (a & b) | (c & d); s3 = (a & ~b) | ~(c & (a | d)).
REQ-016 Selected result y SHALL be:
  - SEL_S1 (00): s1
  - SEL_S2 (01): s2
  - SEL_S3 (10): s3
  - SEL_XOR (11): s1 ^ s2 ^ s3
REQ-017 Pipeline SHALL have two register stages:
  - stage 1 registers s1, s2, s3 and y;
  - stage 2 registers stage-1 data plus pop.
REQ-018 Latency SHALL be 2 cycles: out_valid rises on the second rising edge after an accepted input.
REQ-019 Input handshake: a transfer occurs when in_valid && in_ready at a rising edge.
REQ-020 Output handshake: a transfer occurs when out_valid && out_ready at a rising edge.
REQ-021 Stage advance rules:
  - adv2 = !v2 || out_ready;
  - adv1 = !v1 || adv2;
  - in_ready = adv1.
  - in_ready is combinational from out_ready; there is no other combinational input-to-output path.
REQ-022 A stage that does not advance SHALL hold all its data bits unchanged.
REQ-023 Outputs s1, s2, s3, y and pop SHALL be stable while out_valid && !out_ready.
REQ-024 When the pipeline is not stalled, throughput SHALL be one transfer per cycle.
REQ-025 With out_ready low and both stages full, in_ready SHALL be 0 and no data is lost or duplicated.
REQ-026 Simultaneous output handshake and input acceptance when full SHALL shift both stages in the same cycle.
REQ-027 txn_count SHALL increment by 1 on each output handshake.
  - It wraps from all-ones to 0 with no flag.
  - It is unaffected by input-side events.
REQ-028 Width rule: pop SHALL be the exact unsigned count of ones, e.g. 8 for WIDTH=8 with y=8'hFF.

Reset
REQ-029 While rst_n=0 at a rising edge, the block SHALL clear:
  - v1 and v2 (out_valid=0);
  - s1, s2, s3, y, pop and txn_count to 0.
REQ-030 While rst_n=0, in_ready SHALL be driven 0.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight transactions; none appears after reset release.
REQ-032 The first input SHALL be accepted in the first cycle in which rst_n=1.

Structure
REQ-033 Package logic_expr_pkg SHALL hold:
  - typedef enum logic [1:0] sel_t {SEL_S1, SEL_S2, SEL_S3, SEL_XOR};
  - default constants WIDTH_DEF=8 and CNT_W_DEF=16.
REQ-034 Combinational sub-module logic_expr_core (parameter WIDTH) SHALL compute s1, s2, s3 and y from a, b, c, d and sel.
REQ-035 logic_expr_pipe SHALL instantiate logic_expr_core once and own all registers and handshake logic.

Verification
REQ-036 Basic, WIDTH=8:
  - stimulus: a=F0, b=CC, c=AA, d=0F, sel=01, out_ready=1;
  - response, 2 cycles later: s1=30, s2=CA, s3=75, y=CA, pop=4, txn_count=1.
REQ-037 XOR mode: same operands with sel=11 -> y=8F, pop=5.
REQ-038 Backpressure:
  - stimulus: 4 back-to-back inputs with out_ready=0;
  - response: in_ready drops after 2 accepts; outputs stay frozen.
  - then raise out_ready: all 4 results emerge in order, with none lost or duplicated.
REQ-039 Wrap, CNT_W=4: 17 output handshakes -> txn_count reads 1.
REQ-040 Reset mid-flight: assert rst_n=0 for 1 cycle with both stages full -> out_valid=0 and all outputs 0 next cycle; no stale result later.
REQ-041 Random streaming, WIDTH=1 and 64: random in_valid/out_ready -> every result matches a reference model in order.
